// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, sign fixed up in a final cycle.
module mips_muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb_mag;
   logic [CNT_W-1:0]   count;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dbz;

   function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v,
                                              input logic                    use_sign);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return (use_sign && v[WIDTH-1]) ? n : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_if_w(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic             op_arith;
   logic             op_signed;
   logic             sign_a;
   logic             sign_b;
   logic             zero_div;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   assign op_arith  = ~op[2];
   assign op_signed = ~op[2] & ~op[0];
   assign sign_a    = op_signed & operand_a[WIDTH-1];
   assign sign_b    = op_signed & operand_b[WIDTH-1];
   assign zero_div  = op_arith & op[1] & (operand_b == '0);
   assign mag_a     = abs_w(operand_a, op_signed);
   assign mag_b     = abs_w(operand_b, op_signed);

   // Iteration datapath: acc = {partial product | remainder, multiplier | quotient}
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb_mag : '0)};
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opb_mag};
      div_diff  = div_shift[WIDTH-1:0] - opb_mag;
      div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
   end

   // Sign correction applied in the FIX cycle
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      prod_fix = neg_if_2w(acc, neg_q);
      if (is_div) begin
         fix_hi = neg_if_w(acc[2*WIDTH-1:WIDTH], neg_r);
         fix_lo = neg_if_w(acc[WIDTH-1:0], neg_q);
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         count       <= '0;
         acc         <= '0;
         opb_mag     <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dbz         <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && op_arith) begin
                  // A zero divisor keeps the raw dividend so the remainder path returns it untouched
                  acc     <= {{WIDTH{1'b0}}, (zero_div ? operand_a : mag_a)};
                  opb_mag <= mag_b;
                  is_div  <= op[1];
                  neg_q   <= ~zero_div & (sign_a ^ sign_b);
                  neg_r   <= ~zero_div & sign_a;
                  dbz     <= zero_div;
                  count   <= CNT_W'(WIDTH);
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end else if (start && op == OP_MTHI) begin
                  hi <= operand_a;
               end else if (start && op == OP_MTLO) begin
                  lo <= operand_a;
               end
            end
            S_RUN: begin
               if (cancel) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  acc   <= is_div ? div_next : mul_next;
                  count <= count - CNT_W'(1);
                  if (count == CNT_W'(1)) state <= S_FIX;
               end
            end
            S_FIX: begin
               busy  <= 1'b0;
               state <= S_IDLE;
               if (!cancel) begin
                  hi          <= fix_hi;
                  lo          <= fix_lo;
                  done        <= 1'b1;
                  div_by_zero <= dbz;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized self-checking bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8.
// Expected HI/LO come from plain integer multiply/divide on the operands.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic        use8 = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;

   logic        start32, start8, cancel32, cancel8;
   logic        busy32, done32, dbz32;
   logic [31:0] hi32, lo32;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;
   logic        cur_busy, cur_done, cur_dbz;
   logic [31:0] cur_hi, cur_lo;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_hi[2];
   logic [31:0] exp_lo[2];

   always #5 clk = ~clk;

   assign start32  = start & ~use8;
   assign start8   = start & use8;
   assign cancel32 = cancel & ~use8;
   assign cancel8  = cancel & use8;
   assign cur_busy = use8 ? busy8 : busy32;
   assign cur_done = use8 ? done8 : done32;
   assign cur_dbz  = use8 ? dbz8 : dbz32;
   assign cur_hi   = use8 ? {24'b0, hi8} : hi32;
   assign cur_lo   = use8 ? {24'b0, lo8} : lo32;

   mips_muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst_n), .start(start32), .op(op), .operand_a(opa), .operand_b(opb),
      .cancel(cancel32), .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
   );

   mips_muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst_n), .start(start8), .op(op), .operand_a(opa[7:0]), .operand_b(opb[7:0]),
      .cancel(cancel8), .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (w=%0d): got %h expected %h", tag, use8 ? 8 : 32, got, exp);
      end
   endtask

   // Reference: integer arithmetic on w-bit operands, results truncated to w bits
   task automatic ref_model(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl, output logic rz);
      logic [63:0] mask, ua, ub, t;
      longint      sa, sb, sq, sr;
      mask = (64'd1 << w) - 64'd1;
      ua = {32'b0, a} & mask;
      ub = {32'b0, b} & mask;
      sa = longint'(ua);
      sb = longint'(ub);
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      rz = 1'b0;
      rh = '0;
      rl = '0;
      case (o)
         3'd0: begin
            t  = 64'(sa * sb);
            rh = 32'((t >> w) & mask);
            rl = 32'(t & mask);
         end
         3'd1: begin
            t  = ua * ub;
            rh = 32'((t >> w) & mask);
            rl = 32'(t & mask);
         end
         default: begin
            if (ub == 64'd0) begin
               rz = 1'b1;
               rl = 32'(mask);
               rh = 32'(ua);
            end else if (o == 3'd2) begin
               sq = sa / sb;
               sr = sa % sb;
               rl = 32'(64'(sq) & mask);
               rh = 32'(64'(sr) & mask);
            end else begin
               rl = 32'(ua / ub);
               rh = 32'(ua % ub);
            end
         end
      endcase
   endtask

   function automatic logic [31:0] pick(input int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return m;
         2: return 32'd1 << (w - 1);
         3: return 32'($urandom_range(1, 9));
         default: return $urandom;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input bit cis);
      int          w, s, cycles, busy_cnt;
      logic [31:0] rh, rl, m;
      logic        rz;
      w = use8 ? 8 : 32;
      s = use8 ? 1 : 0;
      m = use8 ? 32'hFF : 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b; cancel = cis;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      if (o[2] == 1'b0) begin
         ref_model(w, o, a, b, rh, rl, rz);
         cycles = 0;
         busy_cnt = 0;
         while (!cur_done && cycles < 200) begin
            if (cur_busy) busy_cnt++;
            cycles++;
            start = (cycles == inject_at);
            if (start) begin
               op = 3'd0; opa = $urandom; opb = $urandom;
            end
            @(negedge clk);
         end
         start = 1'b0;
         check("latency", 64'(cycles), 64'(w + 1));
         check("busy_cycles", 64'(busy_cnt), 64'(w + 1));
         check("hi", {32'b0, cur_hi}, {32'b0, rh});
         check("lo", {32'b0, cur_lo}, {32'b0, rl});
         check("div_by_zero", {63'b0, cur_dbz}, {63'b0, rz});
         check("busy_at_done", {63'b0, cur_busy}, 64'd0);
         exp_hi[s] = rh;
         exp_lo[s] = rl;
         @(negedge clk);
         check("done_pulse", {63'b0, cur_done}, 64'd0);
         check("dbz_pulse", {63'b0, cur_dbz}, 64'd0);
      end else begin
         if (o == 3'b100) exp_hi[s] = a & m;
         if (o == 3'b101) exp_lo[s] = a & m;
         check("mt_busy", {63'b0, cur_busy}, 64'd0);
         check("mt_done", {63'b0, cur_done}, 64'd0);
         check("mt_hi", {32'b0, cur_hi}, {32'b0, exp_hi[s]});
         check("mt_lo", {32'b0, cur_lo}, {32'b0, exp_lo[s]});
      end
   endtask

   task automatic do_cancel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int k);
      int w, s, done_cnt;
      w = use8 ? 8 : 32;
      s = use8 ? 1 : 0;
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b;
      @(negedge clk);
      start = 1'b0;
      repeat (k - 1) @(negedge clk);
      check("busy_before_cancel", {63'b0, cur_busy}, 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("busy_after_cancel", {63'b0, cur_busy}, 64'd0);
      done_cnt = 0;
      repeat (w + 4) begin
         if (cur_done) done_cnt++;
         @(negedge clk);
      end
      check("cancel_no_done", 64'(done_cnt), 64'd0);
      check("cancel_hi", {32'b0, cur_hi}, {32'b0, exp_hi[s]});
      check("cancel_lo", {32'b0, cur_lo}, {32'b0, exp_lo[s]});
   endtask

   initial begin
      exp_hi[0] = '0; exp_hi[1] = '0;
      exp_lo[0] = '0; exp_lo[1] = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         use8 = (s == 1);
         #1;
         check("rst_busy", {63'b0, cur_busy}, 64'd0);
         check("rst_done", {63'b0, cur_done}, 64'd0);
         check("rst_dbz", {63'b0, cur_dbz}, 64'd0);
         check("rst_hi", {32'b0, cur_hi}, 64'd0);
         check("rst_lo", {32'b0, cur_lo}, 64'd0);
      end
      use8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, -1, 1'b0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
      do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
      do_op(3'd3, 32'h0000_0005, 32'h0000_0000, -1, 1'b0);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
      do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, -1, 1'b0);
      do_cancel(3'd3, 32'd100, 32'd7, 10);
      do_op(3'd3, 32'd100, 32'd7, 12, 1'b0);
      do_cancel(3'd0, 32'h1234_5678, 32'h0000_5678, 33);
      do_op(3'd2, 32'hFFFF_FF9C, 32'd9, -1, 1'b1);

      // MTHI then MTLO on back-to-back cycles
      @(negedge clk);
      start = 1'b1; op = 3'b100; opa = 32'h1234_5678;
      @(negedge clk);
      check("mthi_hi", {32'b0, hi32}, 64'h1234_5678);
      check("mthi_lo", {32'b0, lo32}, {32'b0, exp_lo[0]});
      check("mthi_busy", {63'b0, busy32}, 64'd0);
      op = 3'b101; opa = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      check("mtlo_lo", {32'b0, lo32}, 64'h9ABC_DEF0);
      check("mtlo_hi", {32'b0, hi32}, 64'h1234_5678);
      check("mt_busy_done", {62'b0, busy32, done32}, 64'd0);
      exp_hi[0] = 32'h1234_5678;
      exp_lo[0] = 32'h9ABC_DEF0;
      do_op(3'd6, 32'hDEAD_BEEF, 32'h1, -1, 1'b0);

      for (int i = 0; i < 40; i++)
         do_op(3'($urandom_range(0, 7)), pick(32), pick(32), -1, 1'b0);

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; op = 3'd0; opa = 32'h7654_3210; opb = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", {63'b0, busy32}, 64'd0);
      check("async_rst_done", {63'b0, done32}, 64'd0);
      check("async_rst_hi", {32'b0, hi32}, 64'd0);
      check("async_rst_lo", {32'b0, lo32}, 64'd0);
      exp_hi[0] = '0; exp_hi[1] = '0;
      exp_lo[0] = '0; exp_lo[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;

      use8 = 1'b1;
      do_op(3'd0, 32'h80, 32'h80, -1, 1'b0);
      do_op(3'd2, 32'h80, 32'hFF, -1, 1'b0);
      for (int i = 0; i < 40; i++)
         do_op(3'($urandom_range(0, 7)), pick(8), pick(8), -1, 1'b0);
      do_cancel(3'd2, 32'hF3, 32'h05, 9);
      do_op(3'd1, pick(8), pick(8), 4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
